// File: rtl/imm_gen_pkg.sv
// Shared types and constants for the pipelined immediate generator.
package imm_gen_pkg;

  localparam int IMM_SEL_W      = 4;
  localparam int NUM_XLEN_LEGAL = 2;
  localparam int XLEN_LEGAL [NUM_XLEN_LEGAL] = '{32, 64};

  typedef enum logic [IMM_SEL_W-1:0] {
    IMM_I     = 4'd0,
    IMM_S     = 4'd1,
    IMM_B     = 4'd2,
    IMM_J     = 4'd3,
    IMM_LUI   = 4'd4,
    IMM_AUIPC = 4'd5,
    IMM_ZIMM  = 4'd6,
    IMM_SHAMT = 4'd7
  } imm_sel_e;

  function automatic logic xlen_is_legal(input int xlen);
    xlen_is_legal = 1'b0;
    for (int k = 0; k < NUM_XLEN_LEGAL; k++) begin
      if (xlen == XLEN_LEGAL[k]) begin
        xlen_is_legal = 1'b1;
      end
    end
  endfunction

endpackage

// File: rtl/imm_gen_pipe_if.sv
// Handshake/data bundle between decode, the immediate generator and execute.
interface imm_gen_pipe_if
  import imm_gen_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int TAG_W = 5
);
  logic                 i_valid;
  logic                 o_ready;
  logic [31:0]          i_inst;
  logic [IMM_SEL_W-1:0] i_imm_sel;
  logic [XLEN-1:0]      i_pc;
  logic [TAG_W-1:0]     i_tag;
  logic                 i_flush;
  logic                 o_valid;
  logic                 i_ready;
  logic [XLEN-1:0]      o_imm;
  logic [XLEN-1:0]      o_target;
  logic [XLEN-1:0]      o_pc;
  logic [TAG_W-1:0]     o_tag;
  logic                 o_illegal;

  modport master (
    output i_valid, i_inst, i_imm_sel, i_pc, i_tag, i_flush, i_ready,
    input  o_ready, o_valid, o_imm, o_target, o_pc, o_tag, o_illegal
  );

  modport slave (
    input  i_valid, i_inst, i_imm_sel, i_pc, i_tag, i_flush, i_ready,
    output o_ready, o_valid, o_imm, o_target, o_pc, o_tag, o_illegal
  );
endinterface

// File: rtl/imm_gen_core.sv
// Combinational RISC-V immediate extraction for XLEN 32/64.
// Build macro IMM_GEN_ILLEGAL_CHK_EN enables reporting of reserved selectors.
module imm_gen_core
  import imm_gen_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [31:0]          inst,
  input  logic [IMM_SEL_W-1:0] sel,
  output logic [XLEN-1:0]      imm,
  output logic                 illegal
);

`ifdef IMM_GEN_ILLEGAL_CHK_EN
  localparam logic CHK_EN = 1'b1;
`else
  localparam logic CHK_EN = 1'b0;
`endif

  logic reserved_s;
  logic unused_opcode_s;

  // Opcode bits never contribute to an immediate
  assign unused_opcode_s = ^inst[6:0];

  // Format decode; everything sign-extends from inst[31] except ZIMM and SHAMT
  always_comb begin
    imm        = {XLEN{1'b0}};
    reserved_s = 1'b0;
    case (sel)
      IMM_I:     imm = {{(XLEN-12){inst[31]}}, inst[31:20]};
      IMM_S:     imm = {{(XLEN-12){inst[31]}}, inst[31:25], inst[11:7]};
      IMM_B:     imm = {{(XLEN-12){inst[31]}}, inst[7], inst[30:25], inst[11:8], 1'b0};
      IMM_J:     imm = {{(XLEN-20){inst[31]}}, inst[19:12], inst[20], inst[30:21], 1'b0};
      IMM_LUI,
      IMM_AUIPC: imm = {{(XLEN-20){inst[31]}}, inst[31:12], 12'd0};
      IMM_ZIMM:  imm = {{(XLEN-5){1'b0}}, inst[19:15]};
      IMM_SHAMT: imm = (XLEN == 64) ? {{(XLEN-6){1'b0}}, inst[25:20]}
                                    : {{(XLEN-5){1'b0}}, inst[24:20]};
      default: begin
        imm        = {XLEN{1'b0}};
        reserved_s = 1'b1;
      end
    endcase
  end

  assign illegal = reserved_s & CHK_EN;

endmodule

// File: rtl/imm_gen_pipe.sv
// Pipelined immediate/target generator with output register plus one skid entry.
// Build macro IMM_GEN_ILLEGAL_CHK_EN flags reserved selectors via o_illegal.
module imm_gen_pipe
  import imm_gen_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int TAG_W = 5
) (
  input logic           i_clk,
  input logic           i_reset,
  imm_gen_pipe_if.slave bus
);

  // Entry layout: {illegal, tag, pc, target, imm}
  localparam int ENT_W = 3*XLEN + TAG_W + 1;

  if (!xlen_is_legal(XLEN)) begin : g_bad_xlen
    $error("imm_gen_pipe: XLEN must be 32 or 64");
  end

  logic [XLEN-1:0]  core_imm_s;
  logic             core_illegal_s;
  logic [XLEN-1:0]  target_s;
  logic [ENT_W-1:0] new_ent_s;
  logic [ENT_W-1:0] out_ent_r;
  logic [ENT_W-1:0] skid_ent_r;
  logic             out_valid_r;
  logic             skid_valid_r;
  logic             in_fire_s;
  logic             load_out_s;

  imm_gen_core #(.XLEN(XLEN)) u_core (
    .inst    (bus.i_inst),
    .sel     (bus.i_imm_sel),
    .imm     (core_imm_s),
    .illegal (core_illegal_s)
  );

  // Target adder; a flagged reserved selector carries a zero target
  always_comb begin
    target_s = bus.i_pc + core_imm_s;
`ifdef IMM_GEN_ILLEGAL_CHK_EN
    if (core_illegal_s) begin
      target_s = {XLEN{1'b0}};
    end else begin
      target_s = bus.i_pc + core_imm_s;
    end
`endif
  end

  assign new_ent_s  = {core_illegal_s, bus.i_tag, bus.i_pc, target_s, core_imm_s};
  // o_ready comes only from the skid flag, so no path from i_ready
  assign in_fire_s  = bus.i_valid & ~skid_valid_r;
  assign load_out_s = ~out_valid_r | bus.i_ready;

  // Buffer update: reset beats flush, flush beats the handshake
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      out_valid_r  <= 1'b0;
      skid_valid_r <= 1'b0;
      out_ent_r    <= {ENT_W{1'b0}};
      skid_ent_r   <= {ENT_W{1'b0}};
    end else if (bus.i_flush) begin
      out_valid_r  <= 1'b0;
      skid_valid_r <= 1'b0;
    end else if (load_out_s) begin
      if (skid_valid_r) begin
        out_ent_r    <= skid_ent_r;
        out_valid_r  <= 1'b1;
        skid_valid_r <= 1'b0;
      end else if (in_fire_s) begin
        out_ent_r   <= new_ent_s;
        out_valid_r <= 1'b1;
      end else begin
        out_valid_r <= 1'b0;
      end
    end else if (in_fire_s) begin
      skid_ent_r   <= new_ent_s;
      skid_valid_r <= 1'b1;
    end else begin
      skid_valid_r <= skid_valid_r;
    end
  end

  assign bus.o_valid = out_valid_r;
  assign bus.o_ready = ~skid_valid_r;
  assign {bus.o_illegal, bus.o_tag, bus.o_pc, bus.o_target, bus.o_imm} = out_ent_r;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Directed self-checking bench for imm_gen_pipe (XLEN=32 and XLEN=64 instances).
module tb_imm_gen_pipe;

`ifdef IMM_GEN_ILLEGAL_CHK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_err;

  imm_gen_pipe_if #(.XLEN(32), .TAG_W(5)) b32 ();
  imm_gen_pipe_if #(.XLEN(64), .TAG_W(5)) b64 ();

  imm_gen_pipe #(.XLEN(32), .TAG_W(5)) dut32 (.i_clk(clk), .i_reset(rst), .bus(b32));
  imm_gen_pipe #(.XLEN(64), .TAG_W(5)) dut64 (.i_clk(clk), .i_reset(rst), .bus(b64));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive32(input logic [31:0] inst, input logic [3:0] sel,
                         input logic [31:0] pc, input logic [4:0] tag);
    b32.i_valid = 1'b1; b32.i_inst = inst; b32.i_imm_sel = sel;
    b32.i_pc = pc; b32.i_tag = tag;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive32(32'hFFF00093, 4'd0, 32'h55, 5'd3);
    b32.i_ready = 1'b0; b32.i_flush = 1'b1;
    b64.i_valid = 1'b1; b64.i_inst = 32'h800000B7; b64.i_imm_sel = 4'd4;
    tick(); tick();
    n_cmp++; if (b32.o_valid !== 1'b0) begin n_err++; $display("FAIL rst valid: got %b exp 0", b32.o_valid); end
    n_cmp++; if (b32.o_ready !== 1'b1) begin n_err++; $display("FAIL rst ready: got %b exp 1", b32.o_ready); end
    n_cmp++; if (b32.o_imm !== 32'h0) begin n_err++; $display("FAIL rst imm: got %h exp 0", b32.o_imm); end
    n_cmp++; if (b32.o_target !== 32'h0) begin n_err++; $display("FAIL rst target: got %h exp 0", b32.o_target); end
    n_cmp++; if (b32.o_pc !== 32'h0) begin n_err++; $display("FAIL rst pc: got %h exp 0", b32.o_pc); end
    n_cmp++; if (b32.o_tag !== 5'd0) begin n_err++; $display("FAIL rst tag: got %h exp 0", b32.o_tag); end
    n_cmp++; if (b32.o_illegal !== 1'b0) begin n_err++; $display("FAIL rst illegal: got %b exp 0", b32.o_illegal); end
    n_cmp++; if (b64.o_valid !== 1'b0) begin n_err++; $display("FAIL rst64 valid: got %b exp 0", b64.o_valid); end
    n_cmp++; if (b64.o_imm !== 64'h0) begin n_err++; $display("FAIL rst64 imm: got %h exp 0", b64.o_imm); end
    rst = 1'b0;
    b32.i_valid = 1'b0; b32.i_flush = 1'b0; b32.i_ready = 1'b1;
    b64.i_valid = 1'b0;
  endtask

  task automatic test_i_type();
    drive32(32'hFFF00093, 4'd0, 32'h200, 5'd1);
    tick();
    b32.i_valid = 1'b0;
    n_cmp++; if (b32.o_valid !== 1'b1) begin n_err++; $display("FAIL ityp valid: got %b exp 1", b32.o_valid); end
    n_cmp++; if (b32.o_imm !== 32'hFFFFFFFF) begin n_err++; $display("FAIL ityp imm: got %h exp ffffffff", b32.o_imm); end
    n_cmp++; if (b32.o_target !== 32'h1FF) begin n_err++; $display("FAIL ityp target: got %h exp 1ff", b32.o_target); end
    n_cmp++; if (b32.o_pc !== 32'h200) begin n_err++; $display("FAIL ityp pc: got %h exp 200", b32.o_pc); end
    n_cmp++; if (b32.o_tag !== 5'd1) begin n_err++; $display("FAIL ityp tag: got %h exp 1", b32.o_tag); end
    tick();
    n_cmp++; if (b32.o_valid !== 1'b0) begin n_err++; $display("FAIL ityp drain: got %b exp 0", b32.o_valid); end
  endtask

  task automatic test_formats();
    logic [31:0] v_inst [10];
    logic [3:0]  v_sel  [10];
    logic [31:0] v_pc   [10];
    logic [31:0] v_imm  [10];
    logic [31:0] v_tgt  [10];
    v_inst = '{32'hFE000EE3, 32'hFE20AC23, 32'h001000EF, 32'h800000B7, 32'h12345017,
               32'h800F8073, 32'h03F00093, 32'hFE000EE3, 32'h7FF00093, 32'hFFFFFFFF};
    v_sel  = '{4'd2, 4'd1, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd2, 4'd0, 4'd9};
    v_pc   = '{32'h100, 32'h0, 32'h1000, 32'h0, 32'h10, 32'h0, 32'h0, 32'h2, 32'hFFFFFFFF, 32'h40};
    v_imm  = '{32'hFFFFFFFC, 32'hFFFFFFF8, 32'h800, 32'h80000000, 32'h12345000,
               32'h1F, 32'h1F, 32'hFFFFFFFC, 32'h7FF, 32'h0};
    v_tgt  = '{32'hFC, 32'hFFFFFFF8, 32'h1800, 32'h80000000, 32'h12345010,
               32'h1F, 32'h1F, 32'hFFFFFFFE, 32'h7FE, (CHK ? 32'h0 : 32'h40)};
    b32.i_ready = 1'b1;
    for (int k = 0; k < 10; k++) begin
      drive32(v_inst[k], v_sel[k], v_pc[k], 5'(k + 10));
      tick();
      n_cmp++; if (b32.o_valid !== 1'b1) begin n_err++; $display("FAIL fmt%0d valid: got %b exp 1", k, b32.o_valid); end
      n_cmp++; if (b32.o_ready !== 1'b1) begin n_err++; $display("FAIL fmt%0d ready: got %b exp 1", k, b32.o_ready); end
      n_cmp++; if (b32.o_imm !== v_imm[k]) begin n_err++; $display("FAIL fmt%0d imm: got %h exp %h", k, b32.o_imm, v_imm[k]); end
      n_cmp++; if (b32.o_target !== v_tgt[k]) begin n_err++; $display("FAIL fmt%0d target: got %h exp %h", k, b32.o_target, v_tgt[k]); end
      n_cmp++; if (b32.o_tag !== 5'(k + 10)) begin n_err++; $display("FAIL fmt%0d tag: got %h exp %h", k, b32.o_tag, 5'(k + 10)); end
      n_cmp++; if (b32.o_illegal !== ((k == 9) ? CHK : 1'b0)) begin n_err++; $display("FAIL fmt%0d illegal: got %b", k, b32.o_illegal); end
    end
    b32.i_valid = 1'b0;
    tick();
    n_cmp++; if (b32.o_valid !== 1'b0) begin n_err++; $display("FAIL fmt drain: got %b exp 0", b32.o_valid); end
  endtask

  task automatic test_xlen64();
    logic [31:0] v_inst [6];
    logic [3:0]  v_sel  [6];
    logic [63:0] v_pc   [6];
    logic [63:0] v_imm  [6];
    logic [63:0] v_tgt  [6];
    v_inst = '{32'h800000B7, 32'h800000B7, 32'h03F00093, 32'hFFF00093, 32'hFE000EE3, 32'h7FF00093};
    v_sel  = '{4'd4, 4'd6, 4'd7, 4'd0, 4'd2, 4'd0};
    v_pc   = '{64'h0, 64'h0, 64'h0, 64'h0, 64'h100, 64'hFFFFFFFFFFFFFFFF};
    v_imm  = '{64'hFFFFFFFF80000000, 64'h0, 64'h3F, 64'hFFFFFFFFFFFFFFFF, 64'hFFFFFFFFFFFFFFFC, 64'h7FF};
    v_tgt  = '{64'hFFFFFFFF80000000, 64'h0, 64'h3F, 64'hFFFFFFFFFFFFFFFF, 64'hFC, 64'h7FE};
    b64.i_ready = 1'b1; b64.i_flush = 1'b0;
    for (int k = 0; k < 6; k++) begin
      b64.i_valid = 1'b1; b64.i_inst = v_inst[k]; b64.i_imm_sel = v_sel[k];
      b64.i_pc = v_pc[k]; b64.i_tag = 5'(k);
      tick();
      n_cmp++; if (b64.o_valid !== 1'b1) begin n_err++; $display("FAIL x64_%0d valid: got %b exp 1", k, b64.o_valid); end
      n_cmp++; if (b64.o_imm !== v_imm[k]) begin n_err++; $display("FAIL x64_%0d imm: got %h exp %h", k, b64.o_imm, v_imm[k]); end
      n_cmp++; if (b64.o_target !== v_tgt[k]) begin n_err++; $display("FAIL x64_%0d target: got %h exp %h", k, b64.o_target, v_tgt[k]); end
    end
    b64.i_valid = 1'b0;
    tick();
  endtask

  task automatic test_back_to_back();
    b32.i_ready = 1'b0;
    drive32({12'd1, 20'h00093}, 4'd0, 32'h0, 5'd1);
    tick();
    n_cmp++; if (b32.o_tag !== 5'd1) begin n_err++; $display("FAIL bp c0 tag: got %h exp 1", b32.o_tag); end
    n_cmp++; if (b32.o_ready !== 1'b1) begin n_err++; $display("FAIL bp c0 ready: got %b exp 1", b32.o_ready); end
    drive32({12'd2, 20'h00093}, 4'd0, 32'h0, 5'd2);
    tick();
    n_cmp++; if (b32.o_tag !== 5'd1) begin n_err++; $display("FAIL bp c1 tag: got %h exp 1", b32.o_tag); end
    n_cmp++; if (b32.o_ready !== 1'b0) begin n_err++; $display("FAIL bp c1 ready: got %b exp 0", b32.o_ready); end
    drive32({12'd3, 20'h00093}, 4'd0, 32'h0, 5'd3);
    tick();
    n_cmp++; if (b32.o_valid !== 1'b1) begin n_err++; $display("FAIL bp c2 valid: got %b exp 1", b32.o_valid); end
    n_cmp++; if (b32.o_tag !== 5'd1) begin n_err++; $display("FAIL bp c2 tag: got %h exp 1", b32.o_tag); end
    n_cmp++; if (b32.o_imm !== 32'd1) begin n_err++; $display("FAIL bp c2 imm: got %h exp 1", b32.o_imm); end
    n_cmp++; if (b32.o_ready !== 1'b0) begin n_err++; $display("FAIL bp c2 ready: got %b exp 0", b32.o_ready); end
    b32.i_ready = 1'b1;
    tick();
    n_cmp++; if (b32.o_tag !== 5'd2) begin n_err++; $display("FAIL bp c3 tag: got %h exp 2", b32.o_tag); end
    n_cmp++; if (b32.o_imm !== 32'd2) begin n_err++; $display("FAIL bp c3 imm: got %h exp 2", b32.o_imm); end
    n_cmp++; if (b32.o_ready !== 1'b1) begin n_err++; $display("FAIL bp c3 ready: got %b exp 1", b32.o_ready); end
    tick();
    b32.i_valid = 1'b0;
    n_cmp++; if (b32.o_tag !== 5'd3) begin n_err++; $display("FAIL bp c4 tag: got %h exp 3", b32.o_tag); end
    n_cmp++; if (b32.o_valid !== 1'b1) begin n_err++; $display("FAIL bp c4 valid: got %b exp 1", b32.o_valid); end
    tick();
    n_cmp++; if (b32.o_valid !== 1'b0) begin n_err++; $display("FAIL bp c5 valid: got %b exp 0", b32.o_valid); end
  endtask

  task automatic test_flush();
    b32.i_ready = 1'b0;
    drive32(32'h00400093, 4'd0, 32'h0, 5'd4);
    tick();
    drive32(32'h00500093, 4'd0, 32'h0, 5'd5);
    tick();
    n_cmp++; if (b32.o_ready !== 1'b0) begin n_err++; $display("FAIL fl full ready: got %b exp 0", b32.o_ready); end
    drive32(32'h00600093, 4'd0, 32'h0, 5'd6);
    b32.i_flush = 1'b1;
    tick();
    n_cmp++; if (b32.o_valid !== 1'b0) begin n_err++; $display("FAIL fl valid: got %b exp 0", b32.o_valid); end
    n_cmp++; if (b32.o_ready !== 1'b1) begin n_err++; $display("FAIL fl ready: got %b exp 1", b32.o_ready); end
    b32.i_flush = 1'b0; b32.i_valid = 1'b0; b32.i_ready = 1'b1;
    for (int k = 0; k < 2; k++) begin
      tick();
      n_cmp++; if (b32.o_valid !== 1'b0) begin n_err++; $display("FAIL fl post%0d valid: got %b exp 0", k, b32.o_valid); end
    end
    drive32(32'h00700093, 4'd0, 32'h0, 5'd7);
    b32.i_flush = 1'b1;
    tick();
    n_cmp++; if (b32.o_valid !== 1'b0) begin n_err++; $display("FAIL fl in-xfer valid: got %b exp 0", b32.o_valid); end
    b32.i_flush = 1'b0;
    drive32(32'h00800093, 4'd0, 32'h0, 5'd8);
    tick();
    b32.i_valid = 1'b0;
    n_cmp++; if (b32.o_tag !== 5'd8) begin n_err++; $display("FAIL fl resume tag: got %h exp 8", b32.o_tag); end
    tick();
    n_cmp++; if (b32.o_valid !== 1'b0) begin n_err++; $display("FAIL fl resume drain: got %b exp 0", b32.o_valid); end
  endtask

  task automatic test_reset_midstream();
    b32.i_ready = 1'b0;
    drive32(32'hFE000EE3, 4'd2, 32'h100, 5'd9);
    tick();
    n_cmp++; if (b32.o_target !== 32'hFC) begin n_err++; $display("FAIL mrst target: got %h exp fc", b32.o_target); end
    drive32(32'h00A00093, 4'd0, 32'h0, 5'd10);
    tick();
    rst = 1'b1;
    tick();
    n_cmp++; if (b32.o_valid !== 1'b0) begin n_err++; $display("FAIL mrst valid: got %b exp 0", b32.o_valid); end
    n_cmp++; if (b32.o_imm !== 32'h0) begin n_err++; $display("FAIL mrst imm: got %h exp 0", b32.o_imm); end
    n_cmp++; if (b32.o_target !== 32'h0) begin n_err++; $display("FAIL mrst target0: got %h exp 0", b32.o_target); end
    n_cmp++; if (b32.o_pc !== 32'h0) begin n_err++; $display("FAIL mrst pc: got %h exp 0", b32.o_pc); end
    n_cmp++; if (b32.o_tag !== 5'd0) begin n_err++; $display("FAIL mrst tag: got %h exp 0", b32.o_tag); end
    n_cmp++; if (b32.o_ready !== 1'b1) begin n_err++; $display("FAIL mrst ready: got %b exp 1", b32.o_ready); end
    rst = 1'b0; b32.i_valid = 1'b0; b32.i_ready = 1'b1;
    tick();
    n_cmp++; if (b32.o_valid !== 1'b0) begin n_err++; $display("FAIL mrst post valid: got %b exp 0", b32.o_valid); end
  endtask

  initial begin
    n_cmp = 0; n_err = 0;
    rst = 1'b1;
    b32.i_valid = 1'b0; b32.i_inst = 32'h0; b32.i_imm_sel = 4'd0; b32.i_pc = 32'h0;
    b32.i_tag = 5'd0; b32.i_flush = 1'b0; b32.i_ready = 1'b0;
    b64.i_valid = 1'b0; b64.i_inst = 32'h0; b64.i_imm_sel = 4'd0; b64.i_pc = 64'h0;
    b64.i_tag = 5'd0; b64.i_flush = 1'b0; b64.i_ready = 1'b0;
    test_reset();
    test_i_type();
    test_formats();
    test_xlen64();
    test_back_to_back();
    test_flush();
    test_reset_midstream();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/imm_gen_pipe.md
Name: imm_gen_pipe

Overview:
Pipelined, parametrised immediate generator for the decode stage.
- Extends the combinational I/S/B/J/U extractor with XLEN generalisation and two extra formats: CSR zimm and shift-amount.
- Computes a branch/jump target (pc + imm).
- Sits between fetch/decode and execute, behind a valid/ready handshake with a 2-entry skid buffer, so back-pressure never drops an instruction.

Parameters:
- XLEN, 32, datapath width; legal values 32 or 64. Other values are a compile-time error.
- TAG_W, 5, width of the opaque tag (e.g. rd index or ROB id) carried alongside the immediate.

Ports:
- i_clk  in  1  clock; all state updates on the rising edge.
- i_reset  in  1  synchronous, active-high reset.
- i_valid  in  1  upstream holds a valid instruction.
- o_ready  out  1  block can accept; equals NOT(skid entry occupied).
- i_inst  in  32  instruction word.
- i_imm_sel  in  4  format select (imm_sel_e).
- i_pc  in  XLEN  PC of i_inst.
- i_tag  in  TAG_W  sideband, passed through unchanged.
- i_flush  in  1  kill all buffered entries.
- o_valid  out  1  output entry valid.
- i_ready  in  1  downstream accepts.
- o_imm  out  XLEN  generated immediate.
- o_target  out  XLEN  o_pc + o_imm, modulo 2^XLEN.
- o_pc  out  XLEN  registered i_pc.
- o_tag  out  TAG_W  registered i_tag.
- o_illegal  out  1  unsupported selector (see Optional Feature).

Behaviour:
- Reset: synchronous, active-high. At the edge with i_reset=1: o_valid=0; o_imm, o_target, o_pc, o_tag, o_illegal=0; skid empty (o_ready=1 from the next cycle). Reset overrides flush and any handshake in the same cycle.
- Formats (sign extension from inst[31] to XLEN unless stated):
  - 0 I: inst[31:20]
  - 1 S: {inst[31:25], inst[11:7]}
  - 2 B: {inst[31], inst[7], inst[30:25], inst[11:8], 0}
  - 3 J: {inst[31], inst[19:12], inst[20], inst[30:21], 0}
  - 4 LUI and 5 AUIPC: {inst[31:12], 12'b0}, sign-extended to XLEN when XLEN=64.
  - 6 ZIMM: zero-extended inst[19:15].
  - 7 SHAMT: zero-extended inst[25:20] if XLEN=64, else inst[24:20].
  - 8..15: reserved; o_imm=0.
- o_target is computed for every format and is meaningful only for B, J, and AUIPC. Overflow wraps modulo 2^XLEN.
- Handshake:
  - Input transfer when i_valid & o_ready; output transfer when o_valid & i_ready.
  - Latency: exactly 1 cycle from input transfer to o_valid.
  - Throughput: 1 per cycle while i_ready=1.
  - o_ready depends only on registered state, with no combinational path from i_ready.
- Buffering: output register plus one skid entry.
  - Output register empty, or transferring this cycle: the new input (or the skid entry, if occupied) loads into the output register.
  - Output register held (o_valid & !i_ready) and input transfers: the input goes to the skid entry, and o_ready drops next cycle.
  - Skid entry drains into the output register on the first cycle i_ready=1. Order is strictly preserved (skid entry ahead of any new input).
  - Output fields are stable while o_valid & !i_ready.
- Flush: i_flush=1 empties both entries at the next edge (o_valid=0, o_ready=1). A same-cycle input transfer is discarded. A same-cycle output transfer completes normally, since downstream already sampled it.

Optional Feature:
- Macro IMM_GEN_ILLEGAL_CHK_EN.
  - Defined: selectors 8..15 set o_illegal=1 for that entry (registered with it). o_imm and o_target are 0. The entry is still delivered.
  - Undefined: o_illegal is tied to 0; reserved selectors still yield o_imm=0.

Decomposition:
- Package imm_gen_pkg:
  - enum imm_sel_e (IMM_I..IMM_SHAMT, 4-bit).
  - IMM_SEL_W=4.
  - Localparam list of legal XLEN values.
- Sub-module imm_gen_core: purely combinational format extraction (inst, sel -> imm, illegal), parametrised by XLEN, instantiated once ahead of the register stage.

Test Plan:
- XLEN=32, I-type inst 0xFFF00093 (addi x1,x0,-1), sel=0, i_ready=1 -> one cycle later o_valid=1, o_imm=0xFFFFFFFF.
- B-type inst 0xFE000EE3 (beq, offset -4), pc=0x100 -> o_imm=0xFFFFFFFC, o_target=0x000000FC.
- XLEN=64, LUI inst 0x800000B7 -> o_imm=0xFFFFFFFF80000000. Same instruction with sel=6 (ZIMM) -> o_imm=0.
- Back-pressure: stream tags 1,2,3 back-to-back, i_ready=0 from cycle 1 -> tag1 held in output, tag2 in skid, o_ready=0, tag3 held upstream; release i_ready -> outputs 1,2,3 in order, none lost or duplicated.
- Flush with both entries full and i_valid=1 -> next cycle o_valid=0, o_ready=1, flushed tags never appear.
- With IMM_GEN_ILLEGAL_CHK_EN, sel=9 -> o_illegal=1, o_imm=0, o_target=0. Without the macro -> o_illegal=0. Assert reset mid-stream -> all outputs 0 the next cycle.
